seq_mult: RTL and testbench
===========================

# seq_mult

Iterative 8-bit product engine driving the checker stage. On `start` it multiplies `ITERATIONS+1` consecutive `data_in` samples into a running product, truncated or saturated to `WIDTH` bits. It then presents the product on `data_out` with a one-cycle `valid` pulse. It is the design under test that the checker compares against its own model.

## Interface

**Parameters**
- `ITERATIONS`, default `` `MAGIC_NUMBER ``: sample count minus one.
  - Must be below `` `MAX_COUNT ``.
  - Violation is an elaboration-time `$fatal`.
- `WIDTH`, default 8: data path width.
- `SATURATE`, default 0: 0 keeps the low `WIDTH` bits; 1 clamps to all-ones on overflow.

**Ports** (all reset values are 0)
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: run request, sampled only in IDLE.
- `data_in`, input, `WIDTH`: operand sample.
- `valid`, output, 1: product ready. One-cycle pulse.
- `data_out`, output, `WIDTH`: product. Held until the next run completes.
- `busy`, output, 1: high whenever state ≠ IDLE.
- `overflow`, output, 1: sticky for the current run.
  - Set if any full-width product exceeds `WIDTH` bits.
  - Cleared on run start.

## Operation

**States:** IDLE, RUN, DONE. Reset enters IDLE.

**IDLE**
- `start`=1 at an edge: `acc`←1, `count`←0, `overflow`←0, go to RUN.
- `data_in` is ignored.

**RUN**
- Every edge:
  - `acc` ← `acc*data_in`, truncated to `WIDTH` bits, or saturated when `SATURATE`=1.
  - `count` ← `count`+1.
- Overflow detection uses the full 2·`WIDTH`-bit product.
- Once saturated, `acc` stays all-ones. With `SATURATE`=1, a later `data_in`=0 still yields 0.
- The edge with `count`==`ITERATIONS` performs the final multiply and goes to DONE. Total samples = `ITERATIONS`+1.

**DONE**
- `valid`=1 and `data_out`=`acc` for exactly one cycle, then IDLE.
- `start` is ignored in DONE.

**Other rules**
- `start` in RUN or DONE is ignored, not queued.
- `count` width is `$clog2(ITERATIONS+2)`. `count` never exceeds `ITERATIONS`.
- `data_out` is registered. It updates only on entry to DONE.

## Timing

- Call the edge that samples `start`=1 in IDLE edge 0.
- `data_in` is sampled at edges 1 … `ITERATIONS`+1.
- `valid` is high in the cycle after edge `ITERATIONS`+1. Latency from edge 0 to `valid` = `ITERATIONS`+2 edges.
- `busy` rises after edge 0 and falls after the DONE cycle.
- Minimum start-to-start spacing = `ITERATIONS`+3 cycles. With `start` held high, a new run begins at the first edge after returning to IDLE.
- Reset asserted mid-run, at any state, is asynchronous:
  - All outputs clear immediately and the run is discarded.
  - No `valid` is produced.
  - The first run after reset deassertion behaves normally.
- `valid` and `overflow` are both valid during the DONE cycle. `overflow` remains readable until the next run starts.

## Structure

- Shared package `seq_mult_pkg` holds the state enum `seq_mult_state_t` (IDLE, RUN, DONE).
- `MAGIC_NUMBER` and `MAX_COUNT` stay in the common constants header. The block includes that header and defines no duplicates.
- Sub-module `iter_counter`: loadable up-counter with terminal-count flag (`count`==`ITERATIONS`) and a parameterised width.
- The multiply/saturate logic stays inline in `seq_mult`.

## Test plan

All scenarios use `ITERATIONS`=3 unless stated.

1. **Basic run:** `start` pulse, `data_in`=2 for four samples → `valid` one cycle, 5 edges after start. `data_out`=0x10, `overflow`=0.
2. **Overflow, truncating:** `data_in`=0x10 ×4, `SATURATE`=0 → `data_out`=0x00, `overflow`=1. With `SATURATE`=1 → `data_out`=0xFF, `overflow`=1.
3. **Start while busy:** extra `start` pulses during RUN and DONE → exactly one `valid`, `data_out` unchanged by the extra pulses, `busy` low for ≥1 cycle afterwards.
4. **Zero operand:** samples 3, 0, 5, 7 → `data_out`=0x00, `overflow`=0.
5. **Reset mid-run:** `rst` asserted at edge 2, asynchronously between edges → `valid`, `busy`, `data_out` and `overflow` read 0 immediately. No `valid` appears. The next run with `data_in`=3 ×4 gives `data_out`=0x51.
6. **Held start, default parameter:** `start` held high, `ITERATIONS`=`` `MAGIC_NUMBER `` → `valid` pulses periodically every `ITERATIONS`+3 cycles, each product matching the checker model.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared types for the seq_mult iterative product engine.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_mult_state_t;

endpackage

// File: rtl/common_constants.sv
// Common constants header shared across the checker codebase.
// Guarded so it may be included from several compilation units.
`ifndef COMMON_CONSTANTS_SV
`define COMMON_CONSTANTS_SV
`define MAGIC_NUMBER 5
`define MAX_COUNT 16
`endif

// File: rtl/seq_mult_iter_counter.sv
// Loadable up-counter with a terminal-count flag at count == TERMINAL.
module iter_counter #(
  parameter int WIDTH    = 3,
  parameter int TERMINAL = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] TC_VALUE = WIDTH'(TERMINAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= '0;
    else if (en)
      count <= count + WIDTH'(1);
  end

  assign tc = (count == TC_VALUE);

endmodule

// File: rtl/seq_mult.sv
// Iterative product engine: multiplies ITERATIONS+1 consecutive samples,
// truncating or saturating to WIDTH bits, and pulses valid with the result.
`include "common_constants.sv"

module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int ITERATIONS = `MAGIC_NUMBER,
  parameter int WIDTH      = 8,
  parameter int SATURATE   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             valid,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             overflow
);

  localparam int CW = $clog2(ITERATIONS + 2);

  if (ITERATIONS >= `MAX_COUNT) begin : g_iter_range
    $fatal(1, "seq_mult: ITERATIONS must be below MAX_COUNT");
  end

  seq_mult_state_t    state;
  logic [WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0] product;
  logic               prod_ovf;
  logic [WIDTH-1:0]   next_acc;
  logic [CW-1:0]      count;
  logic               tc;
  logic               cnt_load;
  logic               cnt_en;

  // Overflow is judged on the full double-width product; a saturated acc
  // times 0 still collapses to 0 because the multiply is always performed.
  always_comb begin
    product  = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, data_in};
    prod_ovf = |product[2*WIDTH-1:WIDTH];
    next_acc = (SATURATE != 0 && prod_ovf) ? '1 : product[WIDTH-1:0];
  end

  assign cnt_load = (state == IDLE) && start;
  assign cnt_en   = (state == RUN) && !tc;

  iter_counter #(
    .WIDTH    (CW),
    .TERMINAL (ITERATIONS)
  ) u_iter_counter (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .en    (cnt_en),
    .count (count),
    .tc    (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      data_out <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= WIDTH'(1);
            overflow <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          acc      <= next_acc;
          overflow <= overflow | prod_ovf;
          if (tc) begin
            data_out <= next_acc;
            valid    <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          valid <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// Directed bench for seq_mult: truncating and saturating instances at
// ITERATIONS=3, plus a default-parameter instance with start held high.
`include "common_constants.sv"

module tb_seq_mult;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data_in;
  logic       start_c;
  logic [7:0] data_in_c;

  logic       valid_a, busy_a, ovf_a;
  logic [7:0] data_out_a;
  logic       valid_b, busy_b, ovf_b;
  logic [7:0] data_out_b;
  logic       valid_c, busy_c, ovf_c;
  logic [7:0] data_out_c;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  seq_mult #(.ITERATIONS(3), .WIDTH(8), .SATURATE(0)) u_a (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .valid(valid_a), .data_out(data_out_a), .busy(busy_a), .overflow(ovf_a)
  );

  seq_mult #(.ITERATIONS(3), .WIDTH(8), .SATURATE(1)) u_b (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .valid(valid_b), .data_out(data_out_b), .busy(busy_b), .overflow(ovf_b)
  );

  seq_mult #(.WIDTH(8)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .data_in(data_in_c),
    .valid(valid_c), .data_out(data_out_c), .busy(busy_c), .overflow(ovf_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launches a run on the shared inputs and stops just after the final sample edge.
  task automatic feed(input logic [7:0] s0, input logic [7:0] s1,
                      input logic [7:0] s2, input logic [7:0] s3);
    logic [7:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("busy_in_run", busy_a, 1'b1);
      chk("no_early_valid", valid_a, 1'b0);
      data_in = s[i];
      step();
    end
  endtask

  logic [7:0]  exp_c;
  logic        ovf_m;
  logic [15:0] full;
  logic [7:0]  v;

  initial begin
    rst = 1'b1; start = 1'b0; data_in = '0; start_c = 1'b0; data_in_c = '0;
    #12;
    chk("rst_valid", valid_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_data_out", data_out_a, 8'h00);
    chk("rst_overflow", ovf_a, 1'b0);
    rst = 1'b0;
    step();

    // Basic run: 2^4
    feed(8'd2, 8'd2, 8'd2, 8'd2);
    chk("t1_valid", valid_a, 1'b1);
    chk("t1_data_a", data_out_a, 8'h10);
    chk("t1_ovf_a", ovf_a, 1'b0);
    chk("t1_data_b", data_out_b, 8'h10);
    chk("t1_valid_b", valid_b, 1'b1);
    step();
    chk("t1_valid_fall", valid_a, 1'b0);
    chk("t1_busy_fall", busy_a, 1'b0);
    chk("t1_data_hold", data_out_a, 8'h10);

    // Overflow: truncating vs saturating
    feed(8'h10, 8'h10, 8'h10, 8'h10);
    chk("t2_data_trunc", data_out_a, 8'h00);
    chk("t2_ovf_trunc", ovf_a, 1'b1);
    chk("t2_data_sat", data_out_b, 8'hFF);
    chk("t2_ovf_sat", ovf_b, 1'b1);
    step();
    chk("t2_ovf_sticky", ovf_b, 1'b1);
    chk("t2_valid_fall", valid_b, 1'b0);

    // Reset between edges after edge 2 of a run
    start = 1'b1;
    step();
    start = 1'b0; data_in = 8'h10;
    step();
    step();
    chk("t5_busy_pre", busy_a, 1'b1);
    chk("t5_ovf_pre", ovf_a, 1'b1);
    chk("t5_data_b_pre", data_out_b, 8'hFF);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_valid_a", valid_a, 1'b0);
    chk("t5_busy_a", busy_a, 1'b0);
    chk("t5_ovf_a", ovf_a, 1'b0);
    chk("t5_busy_b", busy_b, 1'b0);
    chk("t5_ovf_b", ovf_b, 1'b0);
    chk("t5_data_b", data_out_b, 8'h00);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t5_no_valid", valid_a | valid_b, 1'b0);
    end
    feed(8'd3, 8'd3, 8'd3, 8'd3);
    chk("t5_data_a", data_out_a, 8'h51);
    chk("t5_data_b_after", data_out_b, 8'h51);
    chk("t5_ovf_after", ovf_a, 1'b0);
    step();

    // Start pulses during RUN and DONE are ignored
    start = 1'b1;
    step();
    start = 1'b0; data_in = 8'd1;
    step();
    chk("t3_valid_e1", valid_a, 1'b0);
    start = 1'b1; data_in = 8'd2;
    step();
    chk("t3_valid_e2", valid_a, 1'b0);
    start = 1'b0; data_in = 8'd3;
    step();
    chk("t3_valid_e3", valid_a, 1'b0);
    start = 1'b1; data_in = 8'd4;
    step();
    chk("t3_valid_done", valid_a, 1'b1);
    chk("t3_data", data_out_a, 8'h18);
    step();
    chk("t3_valid_e5", valid_a, 1'b0);
    chk("t3_busy_e5", busy_a, 1'b0);
    start = 1'b0;
    step();
    chk("t3_busy_e6", busy_a, 1'b0);
    chk("t3_valid_e6", valid_a, 1'b0);
    chk("t3_data_hold", data_out_a, 8'h18);
    step();
    chk("t3_busy_e7", busy_a, 1'b0);
    chk("t3_valid_e7", valid_a, 1'b0);

    // Zero operand
    feed(8'd3, 8'd0, 8'd5, 8'd7);
    chk("t4_data_a", data_out_a, 8'h00);
    chk("t4_ovf_a", ovf_a, 1'b0);
    chk("t4_data_b", data_out_b, 8'h00);
    chk("t4_ovf_b", ovf_b, 1'b0);
    step();

    // Held start on the default-parameter instance: period ITERATIONS+3
    start_c = 1'b1;
    step();
    exp_c = 8'd1; ovf_m = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < `MAGIC_NUMBER + 3; j++) begin
        if (j == 0) begin
          exp_c = 8'd1; ovf_m = 1'b0;
          chk("t6_busy_start", busy_c, 1'b1);
          chk("t6_valid_start", valid_c, 1'b0);
        end else if (j == `MAGIC_NUMBER + 1) begin
          chk("t6_valid", valid_c, 1'b1);
          chk("t6_data", data_out_c, exp_c);
          chk("t6_ovf", ovf_c, ovf_m);
        end else if (j == `MAGIC_NUMBER + 2) begin
          chk("t6_valid_fall", valid_c, 1'b0);
          chk("t6_busy_fall", busy_c, 1'b0);
        end else begin
          chk("t6_no_valid", valid_c, 1'b0);
        end
        if (j <= `MAGIC_NUMBER) begin
          v = 8'(r * 5 + j + 2);
          data_in_c = v;
          full = 16'(exp_c) * 16'(v);
          ovf_m = ovf_m | (full > 16'd255);
          exp_c = full[7:0];
        end
        step();
      end
    end
    start_c = 1'b0;
    repeat (10) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
